// File: rtl/priority_encoder_if.sv
// Bundle for the TLB match-vector priority encoder: raw match vector in,
// combinational and registered encode results out.
interface priority_encoder_if #(
    parameter int OUT_WIDTH = 3
);
    localparam int N = 1 << OUT_WIDTH;

    logic [N-1:0]         in;
    logic [OUT_WIDTH-1:0] out;
    logic                 found;
    logic                 multi;
    logic [OUT_WIDTH-1:0] out_q;
    logic                 found_q;
    logic                 multi_q;

    modport master (
        output in,
        input  out, found, multi, out_q, found_q, multi_q
    );

    modport slave (
        input  in,
        output out, found, multi, out_q, found_q, multi_q
    );
endinterface

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder for the TLB comparator outputs, with hit
// and multi-hit flags, plus a one-cycle registered copy of all results.
module priority_encoder #(
    parameter int OUT_WIDTH = 3
) (
    input  logic               clk,
    input  logic               res,
    priority_encoder_if.slave  bus
);
    localparam int N = 1 << OUT_WIDTH;

    logic [N-1:0]         inMinusOne;
    logic [OUT_WIDTH-1:0] out_d;
    logic                 found_d;
    logic                 multi_d;
    logic [OUT_WIDTH-1:0] out_q;
    logic                 found_q;
    logic                 multi_q;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        out_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in[i]) begin
                out_d = OUT_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only on a multi-hit.
    assign inMinusOne = bus.in - {{(N-1){1'b0}}, 1'b1};
    assign found_d    = |bus.in;
    assign multi_d    = |(bus.in & inMinusOne);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            out_q   <= '0;
            found_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            found_q <= found_d;
            multi_q <= multi_d;
        end
    end

    assign bus.out     = out_d;
    assign bus.found   = found_d;
    assign bus.multi   = multi_d;
    assign bus.out_q   = out_q;
    assign bus.found_q = found_q;
    assign bus.multi_q = multi_q;
endmodule

// File: tb/tb_priority_encoder.sv
// Directed checks of the priority encoder at OUT_WIDTH=3 plus a randomised
// width sweep (1, 4, 6) against an independent lowest-bit/popcount model.
module tb_priority_encoder;
    logic clk;
    logic res;
    int   checks;
    int   errors;

    priority_encoder_if #(.OUT_WIDTH(3)) bus3 ();
    priority_encoder_if #(.OUT_WIDTH(1)) bus1 ();
    priority_encoder_if #(.OUT_WIDTH(4)) bus4 ();
    priority_encoder_if #(.OUT_WIDTH(6)) bus6 ();

    priority_encoder #(.OUT_WIDTH(3)) dut3 (.clk(clk), .res(res), .bus(bus3.slave));
    priority_encoder #(.OUT_WIDTH(1)) dut1 (.clk(clk), .res(res), .bus(bus1.slave));
    priority_encoder #(.OUT_WIDTH(4)) dut4 (.clk(clk), .res(res), .bus(bus4.slave));
    priority_encoder #(.OUT_WIDTH(6)) dut6 (.clk(clk), .res(res), .bus(bus6.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] vec);
        bus3.in = vec;
        #1;
    endtask

    function automatic int refLow(input logic [63:0] v, input int n);
        int idx;
        bit seen;
        idx  = 0;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (v[i] && !seen) begin
                idx  = i;
                seen = 1;
            end
        end
        return idx;
    endfunction

    function automatic int refCount(input logic [63:0] v, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (v[i]) cnt++;
        end
        return cnt;
    endfunction

    task automatic checkSweep(input string tag, input logic [63:0] v, input int n,
                              input int gotOut, input int gotFound, input int gotMulti);
        checkOutput({tag, "_out"},   gotOut,   refLow(v, n));
        checkOutput({tag, "_found"}, gotFound, (refCount(v, n) >= 1) ? 1 : 0);
        checkOutput({tag, "_multi"}, gotMulti, (refCount(v, n) >= 2) ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [7:0] latVec [4];
        int         latOut [4];
        int         latFnd [4];
        int         latMul [4];
        int         prevOut;
        int         prevFnd;
        int         prevMul;

        latVec = '{8'h01, 8'h02, 8'h0C, 8'h00};
        latOut = '{0, 1, 2, 0};
        latFnd = '{1, 1, 1, 0};
        latMul = '{0, 0, 1, 0};
        checks = 0;
        errors = 0;

        res     = 1'b0;
        bus1.in = '0;
        bus4.in = '0;
        bus6.in = '0;
        bus3.in = 8'h40;
        #3;
        checkOutput("rst_out_q",   int'(bus3.out_q),   0);
        checkOutput("rst_found_q", int'(bus3.found_q), 0);
        checkOutput("rst_multi_q", int'(bus3.multi_q), 0);
        checkOutput("rst_comb_out", int'(bus3.out),    6);
        tick();
        checkOutput("rst_hold_found_q", int'(bus3.found_q), 0);
        @(negedge clk);
        res = 1'b1;

        // Exhaustive one-hot sweep.
        for (int i = 0; i < 8; i++) begin
            tick();
            applyStimulus(8'(1 << i));
            checkOutput($sformatf("onehot%0d_out", i),   int'(bus3.out),   i);
            checkOutput($sformatf("onehot%0d_found", i), int'(bus3.found), 1);
            checkOutput($sformatf("onehot%0d_multi", i), int'(bus3.multi), 0);
            tick();
            checkOutput($sformatf("onehot%0d_out_q", i),   int'(bus3.out_q),   i);
            checkOutput($sformatf("onehot%0d_found_q", i), int'(bus3.found_q), 1);
            checkOutput($sformatf("onehot%0d_multi_q", i), int'(bus3.multi_q), 0);
        end

        applyStimulus(8'h00);
        checkOutput("zero_out",   int'(bus3.out),   0);
        checkOutput("zero_found", int'(bus3.found), 0);
        checkOutput("zero_multi", int'(bus3.multi), 0);
        tick();
        checkOutput("zero_found_q", int'(bus3.found_q), 0);

        applyStimulus(8'hA0);
        checkOutput("a0_out",   int'(bus3.out),   5);
        checkOutput("a0_multi", int'(bus3.multi), 1);
        tick();
        checkOutput("a0_multi_q", int'(bus3.multi_q), 1);
        applyStimulus(8'hFF);
        checkOutput("ff_out",   int'(bus3.out),   0);
        checkOutput("ff_multi", int'(bus3.multi), 1);
        applyStimulus(8'h81);
        checkOutput("81_out",   int'(bus3.out),   0);
        checkOutput("81_multi", int'(bus3.multi), 1);
        applyStimulus(8'h24);
        checkOutput("24_out",   int'(bus3.out),   2);
        checkOutput("24_found", int'(bus3.found), 1);
        checkOutput("24_multi", int'(bus3.multi), 1);

        // Asynchronous reset between edges, then release.
        tick();
        applyStimulus(8'h40);
        tick();
        checkOutput("ar_load_out_q",   int'(bus3.out_q),   6);
        checkOutput("ar_load_found_q", int'(bus3.found_q), 1);
        #2;
        res = 1'b0;
        #1;
        checkOutput("ar_out_q",   int'(bus3.out_q),   0);
        checkOutput("ar_found_q", int'(bus3.found_q), 0);
        checkOutput("ar_multi_q", int'(bus3.multi_q), 0);
        checkOutput("ar_comb_out", int'(bus3.out),    6);
        @(negedge clk);
        res = 1'b1;
        tick();
        checkOutput("ar_release_out_q",   int'(bus3.out_q),   6);
        checkOutput("ar_release_found_q", int'(bus3.found_q), 1);

        // Registered latency: one cycle behind the input.
        prevOut = 6;
        prevFnd = 1;
        prevMul = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(latVec[k]);
            checkOutput($sformatf("lat%0d_pre_out_q", k), int'(bus3.out_q), prevOut);
            checkOutput($sformatf("lat%0d_pre_found_q", k), int'(bus3.found_q), prevFnd);
            checkOutput($sformatf("lat%0d_pre_multi_q", k), int'(bus3.multi_q), prevMul);
            tick();
            checkOutput($sformatf("lat%0d_out_q", k),   int'(bus3.out_q),   latOut[k]);
            checkOutput($sformatf("lat%0d_found_q", k), int'(bus3.found_q), latFnd[k]);
            checkOutput($sformatf("lat%0d_multi_q", k), int'(bus3.multi_q), latMul[k]);
            prevOut = latOut[k];
            prevFnd = latFnd[k];
            prevMul = latMul[k];
        end

        // Width sweep with sparse and dense random vectors.
        for (int r = 0; r < 24; r++) begin
            if (r % 3 == 0) begin
                bus1.in = 2'($urandom() & $urandom());
                bus4.in = 16'($urandom() & $urandom() & $urandom());
                bus6.in = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
            end else if (r % 3 == 1) begin
                bus1.in = 2'($urandom());
                bus4.in = 16'($urandom());
                bus6.in = {$urandom(), $urandom()};
            end else begin
                bus1.in = 2'(1 << $urandom_range(1, 0));
                bus4.in = 16'(1 << $urandom_range(15, 0));
                bus6.in = 64'(1) << $urandom_range(63, 0);
            end
            #1;
            checkSweep($sformatf("w1_%0d", r), 64'(bus1.in), 2,
                       int'(bus1.out), int'(bus1.found), int'(bus1.multi));
            checkSweep($sformatf("w4_%0d", r), 64'(bus4.in), 16,
                       int'(bus4.out), int'(bus4.found), int'(bus4.multi));
            checkSweep($sformatf("w6_%0d", r), bus6.in, 64,
                       int'(bus6.out), int'(bus6.found), int'(bus6.multi));
            tick();
            checkOutput($sformatf("w6_%0d_out_q", r), int'(bus6.out_q), refLow(bus6.in, 64));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_encoder.md
# priority_encoder

Parameterised priority encoder converting a 2^OUT_WIDTH-bit match vector into the binary index of its lowest set bit, with a hit flag and a multi-hit flag. It sits behind the TLB's per-entry comparators, producing the matched entry index in the same cycle as the lookup. A registered copy of all results is also provided for pipelined consumers.

## Interface
- OUT_WIDTH, default 3: width of the encoded index; input width is N = 2^OUT_WIDTH. Legal range 1..8.
- clk  input  1  clock; all registered outputs update on its rising edge.
- res  input  1  asynchronous, active-low reset.
- in  input  N  match vector; bit i set means entry i matched.
- out  output  OUT_WIDTH  combinational index of the lowest-numbered set bit of `in`.
- found  output  1  combinational; set when `in` has at least one bit set (OR-reduction).
- multi  output  1  combinational; set when `in` has two or more bits set.
- out_q  output  OUT_WIDTH  `out` registered on clk.
- found_q  output  1  `found` registered on clk.
- multi_q  output  1  `multi` registered on clk.

## Operation
- Priority is lowest index first. `out` = smallest i with in[i] = 1.
- Example: in = 8'b0010_0100 gives out = 2, found = 1, multi = 1.
- When in = 0: out = 0, found = 0, multi = 0. Consumers must qualify `out` with `found`.
- One-hot input: out is the exact binary index of the set bit, and multi = 0.
- multi is computed as "in has any bit set other than its lowest set bit", i.e. (in & (in − 1)) != 0, evaluated at N bits.
- Combinational outputs depend only on `in`, never on clk or res.
- Implementation is free to use a tree or a loop. It must be purely combinational, latch-free, and must not produce X for any fully-defined `in`.

## Timing
- out, found, multi: zero latency, combinational from `in`.
- out_q, found_q, multi_q: one-cycle latency. They capture the combinational values at each rising clk edge while res = 1.
- Reset: while res = 0, out_q = 0, found_q = 0, multi_q = 0, immediately and asynchronously, regardless of clk.
- Combinational outputs keep tracking `in` during reset.
- Reset release: the first rising edge after res goes high loads the registers normally. Release is assumed synchronous to clk from an upstream synchroniser.
- Reset asserted mid-stream clears the registers at once. Any pending value is lost, and no partial update occurs.
- There is no enable or handshake: the registers load every cycle.

## Test plan
- Exhaustive one-hot, OUT_WIDTH=3: for i in 0..7 drive in = 1<<i -> out = i, found = 1, multi = 0. On the next edge, out_q = i and found_q = 1.
- Zero input: in = 8'h00 -> out = 0, found = 0, multi = 0. After one edge, found_q = 0.
- Multi-hit priority: in = 8'hA0 -> out = 5, multi = 1. in = 8'hFF -> out = 0, multi = 1. in = 8'h81 -> out = 0, multi = 1.
- Async reset: load in = 8'h40 so out_q = 6 and found_q = 1. Pull res low between edges -> out_q = 0, found_q = 0, multi_q = 0 before the next edge, while combinational out = 6 stays. Release res; the next edge gives out_q = 6.
- Registered latency: change in every cycle through 01, 02, 0C, 00 -> out_q follows 0, 1, 2, 0 exactly one cycle behind, with found_q 1, 1, 1, 0 and multi_q 0, 0, 1, 0.
- Parameter sweep: OUT_WIDTH = 1, 4, 6 with random vectors -> out, found and multi match a reference model of lowest-set-bit, OR-reduction and popcount ≥ 2.
